// File: rtl/prog_loader_uart_pkg.sv
// Shared constants, state encodings and baud divisor helper for the UART program loader.
// Optional checksum stage is enabled by defining PROG_LOADER_CHKSUM_EN.
package prog_loader_uart_pkg;

  localparam logic [7:0] SYNC_BYTE  = 8'hA5;
  localparam int         OVERSAMPLE = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_DATA,
    ST_CHK,
    ST_RUN
  } load_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_DONE
  } rx_state_t;

  // Rounded clocks per oversampling tick, never below one.
  function automatic int baud_divisor(input int clk_hz, input int baud);
    int d;
    d = (clk_hz + (baud * OVERSAMPLE) / 2) / (baud * OVERSAMPLE);
    return (d < 1) ? 1 : d;
  endfunction

endpackage

// File: rtl/prog_loader_uart_rx_byte.sv
// 8N1 UART byte receiver with 16x oversampling, glitch-rejected start bit and framing-error report.
// Part of the prog_loader_uart slice (optional macro PROG_LOADER_CHKSUM_EN does not affect this file).
module uart_rx_byte
  import prog_loader_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       ferr
);

  localparam int          DIV      = baud_divisor(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  logic        rx_meta;
  logic        rx_sync;
  logic        rx_prev;
  logic [15:0] div_cnt;
  logic        tick;
  logic [3:0]  os_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic        stop_ok;
  rx_state_t   rx_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= uart_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Divider restarts on every start edge so ticks are phase-aligned to the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (rx_state == RX_IDLE || div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  assign tick = (rx_state != RX_IDLE) && (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      os_cnt   <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      stop_ok  <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      ferr     <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_prev && !rx_sync) begin
            rx_state <= RX_START;
            os_cnt   <= '0;
          end
        end
        RX_START: begin
          if (tick) begin
            if (os_cnt == 4'd7) begin
              if (rx_sync) begin
                rx_state <= RX_IDLE;
              end else begin
                rx_state <= RX_DATA;
                os_cnt   <= '0;
                bit_idx  <= '0;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        RX_DATA: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              shreg  <= {rx_sync, shreg[7:1]};
              os_cnt <= '0;
              if (bit_idx == 3'd7) begin
                rx_state <= RX_STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        RX_STOP: begin
          if (tick) begin
            if (os_cnt == 4'd15) begin
              stop_ok  <= rx_sync;
              rx_state <= RX_DONE;
            end else begin
              os_cnt <= os_cnt + 4'd1;
            end
          end
        end
        RX_DONE: begin
          rx_valid <= stop_ok;
          ferr     <= !stop_ok;
          if (stop_ok) begin
            rx_data <= shreg;
          end
          rx_state <= RX_IDLE;
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/prog_loader_uart.sv
// Frame FSM that writes a UART-delivered program image into BRAM port B and gates cpu_run.
// Define PROG_LOADER_CHKSUM_EN to require and verify a trailing checksum byte.
module prog_loader_uart
  import prog_loader_uart_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              uart_rx,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output logic              ram_we,
  output logic              cpu_run,
  output logic              load_busy,
  output logic              load_err,
  output logic [7:0]        byte_cnt
);

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        ferr;
  logic [7:0]  len_reg;
  load_state_t state;
`ifdef PROG_LOADER_CHKSUM_EN
  logic [7:0]  checksum;
`endif

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .uart_rx  (uart_rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .ferr     (ferr)
  );

  // A length of zero means 256: the wrap of byte_cnt+1 back to zero ends the frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      len_reg   <= '0;
      ram_addr  <= '0;
      ram_data  <= '0;
      ram_we    <= 1'b0;
      cpu_run   <= 1'b0;
      load_busy <= 1'b0;
      load_err  <= 1'b0;
      byte_cnt  <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
      checksum  <= '0;
`endif
    end else begin
      ram_we <= 1'b0;
      case (state)
        ST_IDLE, ST_RUN: begin
          if (rx_valid && rx_data == SYNC_BYTE) begin
            load_err  <= 1'b0;
            byte_cnt  <= '0;
            cpu_run   <= 1'b0;
            load_busy <= 1'b1;
            state     <= ST_LEN;
`ifdef PROG_LOADER_CHKSUM_EN
            checksum  <= '0;
`endif
          end else if (state == ST_RUN) begin
            cpu_run <= 1'b1;
          end
        end
        ST_LEN: begin
          if (ferr) begin
            load_err  <= 1'b1;
            load_busy <= 1'b0;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            len_reg <= rx_data;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (ferr) begin
            load_err  <= 1'b1;
            load_busy <= 1'b0;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            ram_addr <= ADDR_W'(byte_cnt);
            ram_data <= rx_data;
            ram_we   <= 1'b1;
            byte_cnt <= byte_cnt + 8'd1;
`ifdef PROG_LOADER_CHKSUM_EN
            checksum <= checksum + rx_data;
            if ((byte_cnt + 8'd1) == len_reg) begin
              state <= ST_CHK;
            end
`else
            if ((byte_cnt + 8'd1) == len_reg) begin
              load_busy <= 1'b0;
              state     <= ST_RUN;
            end
`endif
          end
        end
`ifdef PROG_LOADER_CHKSUM_EN
        ST_CHK: begin
          if (ferr) begin
            load_err  <= 1'b1;
            load_busy <= 1'b0;
            state     <= ST_IDLE;
          end else if (rx_valid) begin
            load_busy <= 1'b0;
            if (rx_data == checksum) begin
              cpu_run <= 1'b1;
              state   <= ST_RUN;
            end else begin
              load_err <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
`endif
        default: begin
          load_busy <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_uart.sv
// Self-checking bench for prog_loader_uart: table-driven frames plus reload, reset and 256-byte cases.
// Expectations follow PROG_LOADER_CHKSUM_EN when it is defined for the build.
module tb_prog_loader_uart;

  localparam int CLK_HZ = 1843200;
  localparam int BAUD   = 115200;
  localparam int ADDR_W = 11;
  localparam int BIT_CLKS = 16;
`ifdef PROG_LOADER_CHKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              uart_rx;
  logic [ADDR_W-1:0] ram_addr;
  logic [7:0]        ram_data;
  logic              ram_we;
  logic              cpu_run;
  logic              load_busy;
  logic              load_err;
  logic [7:0]        byte_cnt;

  int checks   = 0;
  int failures = 0;

  logic [ADDR_W-1:0] wr_addr[$];
  logic [7:0]        wr_data[$];
  int                valid_age = 0;
  logic              run_at_valid;
  logic              run_after1;
  logic              we_after1;
  logic              run_after2;

  typedef struct packed {
    logic [3:0]  n_bytes;
    logic [63:0] bytes;
    logic [3:0]  bad_idx;
    logic [3:0]  exp_writes;
    logic [31:0] exp_data;
    logic        exp_err;
    logic        exp_run;
    logic [7:0]  exp_cnt;
  } vec_t;

  vec_t vecs[4];

  prog_loader_uart #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .uart_rx   (uart_rx),
    .ram_addr  (ram_addr),
    .ram_data  (ram_data),
    .ram_we    (ram_we),
    .cpu_run   (cpu_run),
    .load_busy (load_busy),
    .load_err  (load_err),
    .byte_cnt  (byte_cnt)
  );

  always #5 clk = ~clk;

  // Records every port-B write and cpu_run/ram_we in the two clocks after each received byte.
  always @(negedge clk) begin
    if (ram_we) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
    end
    if (valid_age == 1) begin
      run_after1 = cpu_run;
      we_after1  = ram_we;
    end
    if (valid_age == 2) begin
      run_after2 = cpu_run;
    end
    if (dut.rx_valid) begin
      run_at_valid = cpu_run;
      valid_age    = 1;
    end else if (valid_age != 0 && valid_age < 3) begin
      valid_age = valid_age + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic sendByte(input logic [7:0] b, input bit bad_stop);
    uart_rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    uart_rx = bad_stop ? 1'b0 : 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
    uart_rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic clearWrites();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic applyStimulus(input int k);
    clearWrites();
    for (int i = 0; i < int'(vecs[k].n_bytes); i++) begin
      sendByte(vecs[k].bytes[8*i +: 8], (i == int'(vecs[k].bad_idx)));
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic checkVector(input int k);
    int n;
    checkOutput($sformatf("v%0d_writes", k), 32'(wr_addr.size()), 32'(vecs[k].exp_writes));
    n = (wr_addr.size() < int'(vecs[k].exp_writes)) ? wr_addr.size() : int'(vecs[k].exp_writes);
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("v%0d_addr%0d", k, i), 32'(wr_addr[i]), 32'(i));
      checkOutput($sformatf("v%0d_data%0d", k, i), 32'(wr_data[i]), 32'(vecs[k].exp_data[8*i +: 8]));
    end
    checkOutput($sformatf("v%0d_load_err", k), 32'(load_err), 32'(vecs[k].exp_err));
    checkOutput($sformatf("v%0d_cpu_run", k), 32'(cpu_run), 32'(vecs[k].exp_run));
    checkOutput($sformatf("v%0d_byte_cnt", k), 32'(byte_cnt), 32'(vecs[k].exp_cnt));
    checkOutput($sformatf("v%0d_load_busy", k), 32'(load_busy), 32'd0);
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    checkOutput({tag, "_ram_data"}, 32'(ram_data), 32'd0);
    checkOutput({tag, "_ram_we"}, 32'(ram_we), 32'd0);
    checkOutput({tag, "_cpu_run"}, 32'(cpu_run), 32'd0);
    checkOutput({tag, "_load_busy"}, 32'(load_busy), 32'd0);
    checkOutput({tag, "_load_err"}, 32'(load_err), 32'd0);
    checkOutput({tag, "_byte_cnt"}, 32'(byte_cnt), 32'd0);
  endtask

  initial begin
    int bad;

    // Good frame, bad checksum, framing error on 2nd data byte, second good frame.
    vecs[0] = '{n_bytes: 4'd6, bytes: {16'h0000, 8'h66, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5},
                bad_idx: 4'd15, exp_writes: 4'd3, exp_data: 32'h0033_2211,
                exp_err: 1'b0, exp_run: 1'b1, exp_cnt: 8'd3};
    vecs[1] = '{n_bytes: 4'd6, bytes: {16'h0000, 8'h67, 8'h33, 8'h22, 8'h11, 8'h03, 8'hA5},
                bad_idx: 4'd15, exp_writes: 4'd3, exp_data: 32'h0033_2211,
                exp_err: CHK_EN, exp_run: !CHK_EN, exp_cnt: 8'd3};
    vecs[2] = '{n_bytes: 4'd4, bytes: {32'h0000_0000, 8'h22, 8'h11, 8'h03, 8'hA5},
                bad_idx: 4'd3, exp_writes: 4'd1, exp_data: 32'h0000_0011,
                exp_err: 1'b1, exp_run: 1'b0, exp_cnt: 8'd1};
    vecs[3] = '{n_bytes: 4'd5, bytes: {24'h000000, 8'h1D, 8'hC3, 8'h5A, 8'h02, 8'hA5},
                bad_idx: 4'd15, exp_writes: 4'd2, exp_data: 32'h0000_C35A,
                exp_err: 1'b0, exp_run: 1'b1, exp_cnt: 8'd2};

    rst_n   = 1'b0;
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    checkResetValues("reset");
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);

    for (int k = 0; k < 4; k++) begin
      applyStimulus(k);
      checkVector(k);
    end

    // Reload while running: cpu_run drops right after the sync byte and returns after the new image.
    clearWrites();
    sendByte(8'hA5, 1'b0);
    checkOutput("reload_run_at_sync", 32'(run_at_valid), 32'd1);
    checkOutput("reload_run_after_sync", 32'(run_after1), 32'd0);
    checkOutput("reload_busy", 32'(load_busy), 32'd1);
    sendByte(8'h01, 1'b0);
    sendByte(8'hFF, 1'b0);
`ifdef PROG_LOADER_CHKSUM_EN
    checkOutput("reload_run_before_chk", 32'(run_after2), 32'd0);
    sendByte(8'hFF, 1'b0);
    checkOutput("reload_run_at_chk", 32'(run_at_valid), 32'd0);
    checkOutput("reload_run_after_chk", 32'(run_after1), 32'd1);
`else
    checkOutput("reload_run_with_we", 32'(run_after1), 32'd0);
    checkOutput("reload_we_last", 32'(we_after1), 32'd1);
    checkOutput("reload_run_after_we", 32'(run_after2), 32'd1);
`endif
    repeat (20) @(negedge clk);
    checkOutput("reload_writes", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      checkOutput("reload_addr0", 32'(wr_addr[0]), 32'd0);
      checkOutput("reload_data0", 32'(wr_data[0]), 32'hFF);
    end
    checkOutput("reload_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("reload_byte_cnt", 32'(byte_cnt), 32'd1);

    // Asynchronous reset in the middle of a data byte.
    clearWrites();
    sendByte(8'hA5, 1'b0);
    sendByte(8'h03, 1'b0);
    sendByte(8'h11, 1'b0);
    uart_rx = 1'b0;
    repeat (40) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checkResetValues("midreset");
    uart_rx = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    clearWrites();
    sendByte(8'hA5, 1'b0);
    sendByte(8'h02, 1'b0);
    sendByte(8'h5A, 1'b0);
    sendByte(8'hC3, 1'b0);
    sendByte(8'h1D, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("postreset_writes", 32'(wr_addr.size()), 32'd2);
    checkOutput("postreset_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("postreset_byte_cnt", 32'(byte_cnt), 32'd2);
    checkOutput("postreset_load_err", 32'(load_err), 32'd0);

    // LEN=0 loads 256 bytes 00..FF; their sum mod 256 is 0x80.
    clearWrites();
    sendByte(8'hA5, 1'b0);
    sendByte(8'h00, 1'b0);
    for (int i = 0; i < 256; i++) begin
      sendByte(8'(i), 1'b0);
    end
    sendByte(8'h80, 1'b0);
    repeat (20) @(negedge clk);
    checkOutput("full_writes", 32'(wr_addr.size()), 32'd256);
    bad = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] !== ADDR_W'(i) || wr_data[i] !== 8'(i)) bad++;
    end
    checkOutput("full_bad_entries", 32'(bad), 32'd0);
    if (wr_addr.size() == 256) begin
      checkOutput("full_last_addr", 32'(wr_addr[255]), 32'h0FF);
    end
    checkOutput("full_byte_cnt", 32'(byte_cnt), 32'd0);
    checkOutput("full_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("full_load_err", 32'(load_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
